// File: rtl/freq_counter_core.sv
// Edge counter over a programmable gate window, shown as two decimal digits on a
// multiplexed active-high 7-segment display. Define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
`timescale 1ns/1ps
module freq_counter_core #(
  parameter logic [11:0] DEFAULT_PERIOD = 12'd1000,
  parameter int          MUX_BITS       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        signal,
  input  logic        debug_mode,
  input  logic        period_load,
  input  logic [11:0] period,
  output logic [6:0]  segments,
  output logic        digit
);

  logic              r_sync1, r_sync2, r_sync3;
  logic [11:0]       r_period;
  logic [11:0]       r_win;
  logic [6:0]        r_edges;
  logic [6:0]        r_latched;
  logic [MUX_BITS:0] r_mux;

  logic       w_edge;
  logic       w_win_end;
  logic [7:0] w_sum;
  logic [6:0] w_edges_next;
  logic [6:0] w_latch_next;
  logic [7:0] w_split;
  logic [3:0] w_tens;
  logic [3:0] w_units;
  logic [6:0] w_tens_glyph;
  logic [6:0] w_units_glyph;
  logic       w_mux_digit;

  function automatic logic [6:0] f_glyph(input logic [3:0] d);
    case (d)
      4'd0:    f_glyph = 7'h3F;
      4'd1:    f_glyph = 7'h06;
      4'd2:    f_glyph = 7'h5B;
      4'd3:    f_glyph = 7'h4F;
      4'd4:    f_glyph = 7'h66;
      4'd5:    f_glyph = 7'h6D;
      4'd6:    f_glyph = 7'h7D;
      4'd7:    f_glyph = 7'h07;
      4'd8:    f_glyph = 7'h7F;
      4'd9:    f_glyph = 7'h6F;
      default: f_glyph = 7'h00;
    endcase
  endfunction

  // Repeated subtraction is enough: the latched value never exceeds 99.
  function automatic logic [7:0] f_split(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  assign w_edge       = r_sync2 & ~r_sync3;
  assign w_win_end    = (r_win == r_period - 12'd1);
  assign w_sum        = {1'b0, r_edges} + {7'd0, w_edge};
  assign w_edges_next = (w_sum > 8'd127) ? 7'd127 : w_sum[6:0];
  assign w_latch_next = (w_sum > 8'd99) ? 7'd99 : w_sum[6:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= signal;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // A load restarts the window and throws the partial count away; the display keeps its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_period  <= DEFAULT_PERIOD;
      r_win     <= 12'd0;
      r_edges   <= 7'd0;
      r_latched <= 7'd0;
    end else if (period_load) begin
      r_period <= (period == 12'd0) ? 12'd1 : period;
      r_win    <= 12'd0;
      r_edges  <= 7'd0;
    end else if (w_win_end) begin
      r_latched <= w_latch_next;
      r_edges   <= 7'd0;
      r_win     <= 12'd0;
    end else begin
      r_win   <= r_win + 12'd1;
      r_edges <= w_edges_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mux <= '0;
    end else begin
      r_mux <= r_mux + 1'b1;
    end
  end

  assign w_split       = f_split(r_latched);
  assign w_tens        = w_split[7:4];
  assign w_units       = w_split[3:0];
  assign w_units_glyph = f_glyph(w_units);
  assign w_mux_digit   = r_mux[MUX_BITS];

`ifdef LEADING_ZERO_BLANK_EN
  assign w_tens_glyph = (w_tens == 4'd0) ? 7'h00 : f_glyph(w_tens);
`else
  assign w_tens_glyph = f_glyph(w_tens);
`endif

  always_comb begin
    segments = w_units_glyph;
    digit    = w_mux_digit;
    if (debug_mode) begin
      segments = r_edges;
      digit    = r_sync2;
    end else if (w_mux_digit) begin
      segments = w_tens_glyph;
    end
  end

endmodule

// File: tb/tb_freq_counter_core.sv
// Directed bench for freq_counter_core: display glyphs, window timing, saturation,
// period loads, debug view and reset behaviour.
`timescale 1ns/1ps
module tb_freq_counter_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        signal;
  logic        debug_mode;
  logic        period_load;
  logic [11:0] period;
  logic [6:0]  segments;
  logic        digit;

  int checks   = 0;
  int failures = 0;
  int sig_half = 0;
  int sig_cnt  = 0;

  logic sig_d1 = 1'b0, sig_d2 = 1'b0, sig_d3 = 1'b0;
  logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  freq_counter_core dut (
    .clk         (clk),
    .reset       (reset),
    .signal      (signal),
    .debug_mode  (debug_mode),
    .period_load (period_load),
    .period      (period),
    .segments    (segments),
    .digit       (digit)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // square-wave source on the falling edge; sig_half=0 holds it low
  initial begin
    signal = 1'b0;
    forever begin
      @(negedge clk);
      if (sig_half == 0) begin
        signal  = 1'b0;
        sig_cnt = 0;
      end else begin
        sig_cnt = sig_cnt + 1;
        if (sig_cnt >= sig_half) begin
          signal  = ~signal;
          sig_cnt = 0;
        end
      end
    end
  end

  // reference copy of the 2-flop synchronizer plus edge-detect flop
  always @(posedge clk) begin
    sig_d3 <= sig_d2;
    sig_d2 <= sig_d1;
    sig_d1 <= signal;
  end

  function automatic logic [6:0] tens_g(input int t);
`ifdef LEADING_ZERO_BLANK_EN
    if (t == 0) return 7'h00;
`endif
    return glyph_tab[t];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_period(input int p);
    @(posedge clk);
    #1;
    period      = 12'(p);
    period_load = 1'b1;
    @(posedge clk);
    #1;
    period_load = 1'b0;
  endtask

  task automatic check_now(input string tag, input int t, input int u);
    logic [6:0] exp_seg;
    exp_seg = digit ? tens_g(t) : glyph_tab[u];
    chk(tag, {1'b0, segments}, {1'b0, exp_seg});
  endtask

  task automatic check_display(input string tag, input int t, input int u);
    int ones;
    ones = 0;
    repeat (4) begin
      @(negedge clk);
      check_now(tag, t, u);
      ones = ones + int'(digit);
    end
    chk({tag, "_phase"}, 8'(ones), 8'd2);
  endtask

  initial begin
    int exp_cnt;
    logic pulse_prev;

    reset = 1'b1; debug_mode = 1'b0; period_load = 1'b0; period = 12'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_seg", {1'b0, segments}, 8'h3F);
    chk("reset_digit", {7'd0, digit}, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("digit_toggle", {7'd0, digit}, 8'((i / 2) % 2));
    end

    tick(2000);
    check_display("idle_zero", 0, 0);

    // 100-clock window, 20-clock signal period -> 5
    sig_half = 10;
    load_period(100);
    tick(250);
    check_display("win100_five", 0, 5);

    // 1000-clock window -> 50
    load_period(1000);
    tick(2100);
    check_display("win1000_fifty", 5, 0);

    // 4-clock signal period -> 250 edges, display saturates at 99
    sig_half = 2;
    load_period(1000);
    tick(2100);
    tick(600);
    debug_mode = 1'b1;
    @(negedge clk);
    chk("edge_counter_sat", {1'b0, segments}, 8'h7F);
    @(posedge clk);
    #1;
    debug_mode = 1'b0;
    @(negedge clk);
    check_now("debug_exit_sat", 9, 9);
    check_display("sat_99", 9, 9);

    // mid-window load: old value holds until the first 200-clock window ends
    sig_half = 10;
    tick(100);
    load_period(200);
    @(negedge clk);
    check_now("hold_after_load", 9, 9);
    tick(100);
    check_display("hold_mid", 9, 9);
    tick(120);
    check_display("reload_ten", 1, 0);

    // period 0 behaves as a 1-clock window: live count never accumulates
    debug_mode = 1'b1;
    load_period(0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("period0_live", {1'b0, segments}, 8'd0);
    end

    // debug view tracks live count and synchronized signal over 100-clock windows
    load_period(100);
    exp_cnt = 0;
    pulse_prev = 1'b0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (k % 100 == 0) exp_cnt = 0;
      else exp_cnt = exp_cnt + int'(pulse_prev);
      chk("debug_live_count", {1'b0, segments}, 8'(exp_cnt));
      chk("debug_digit", {7'd0, digit}, {7'd0, sig_d2});
      pulse_prev = sig_d2 & ~sig_d3;
    end
    @(posedge clk);
    #1;
    debug_mode = 1'b0;
    @(negedge clk);
    check_now("debug_exit_normal", 0, 5);

    // reset mid-window, then default 1000-clock window
    sig_half = 0;
    tick(5);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_seg", {1'b0, segments}, 8'h3F);
    chk("reset_mid_digit", {7'd0, digit}, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sig_half = 10;
    repeat (1000) @(negedge clk);
    check_now("pre_default_latch", 0, 0);
    @(negedge clk);
    check_now("default_period_latch", 5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
